cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 register file plus exception sequencer for the 5-stage core.
- Consumes the decoder's syscall/eret/mtc0/mfc0 strobes at the commit point, together with external interrupt lines.
- Owns Status, Cause and EPC.
- Sequences the pipeline flush and PC redirect for interrupts, syscall and eret.

---
 rtl/cp0_exc_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cp0_exc_ctrl                                               |
// | Description : Coprocessor-0 register file (Status/Cause/EPC) and         |
// |               exception sequencer. It takes interrupts, syscall and eret |
// |               at the commit point, holds flush, then issues a one-cycle  |
// |               PC redirect.                                               |
// |               Optional macro TIMER_EN adds Count/Compare and the timer   |
// |               interrupt on Cause.IP[7].                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0800,
    parameter int          IRQ_WIDTH    = 5,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 commit_valid,
    output logic                 commit_ready,
    input  logic [31:0]          commit_pc,
    input  logic                 commit_syscall,
    input  logic                 commit_eret,
    input  logic                 commit_mtc0,
    input  logic [4:0]           cp0_waddr,
    input  logic [31:0]          cp0_wdata,
    input  logic [4:0]           cp0_raddr,
    output logic [31:0]          cp0_rdata,
    input  logic [IRQ_WIDTH-1:0] irq,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc
);

    localparam logic [4:0] C_ADDR_COUNT   = 5'd9;
    localparam logic [4:0] C_ADDR_COMPARE = 5'd11;
    localparam logic [4:0] C_ADDR_STATUS  = 5'd12;
    localparam logic [4:0] C_ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] C_ADDR_EPC     = 5'd14;

    localparam logic [4:0] C_EXC_INT = 5'd0;
    localparam logic [4:0] C_EXC_SYS = 5'd8;

    localparam logic [1:0] C_ST_IDLE     = 2'd0;
    localparam logic [1:0] C_ST_FLUSH    = 2'd1;
    localparam logic [1:0] C_ST_REDIRECT = 2'd2;

    // Counter is loaded with the last index and counts down to zero.
    localparam logic [2:0] C_FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    logic [IRQ_WIDTH-1:0] r_irq_meta;
    logic [IRQ_WIDTH-1:0] r_irq_sync;

    logic        r_ie;
    logic        r_exl;
    logic [7:0]  r_im;
    logic [4:0]  r_exc_code;
    logic [1:0]  r_ip_sw;
    logic [31:0] r_epc;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_target;
    logic        r_flush;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic        r_commit_ready;

    logic [5:0]  w_ip_hw;
    logic [7:0]  w_ip;
    logic        w_int_pend;
    logic        w_idle_commit;
    logic        w_take_int;
    logic        w_take_sys;
    logic        w_take_eret;
    logic        w_do_mtc0;
    logic        w_take_any;

`ifdef TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_pend;

    // The timer pending bit shares IP[7] with any irq line mapped there.
    assign w_ip_hw = {{(6-IRQ_WIDTH){1'b0}}, r_irq_sync} | {r_timer_pend, 5'b0};
`else
    assign w_ip_hw = {{(6-IRQ_WIDTH){1'b0}}, r_irq_sync};
`endif

    assign w_ip       = {w_ip_hw, r_ip_sw};
    assign w_int_pend = r_ie & ~r_exl & (|(w_ip & r_im));

    // One event per accepted commit, strictly prioritised.
    assign w_idle_commit = (r_state == C_ST_IDLE) & commit_valid;
    assign w_take_int    = w_idle_commit & w_int_pend;
    assign w_take_sys    = w_idle_commit & ~w_int_pend & commit_syscall;
    assign w_take_eret   = w_idle_commit & ~w_int_pend & ~commit_syscall & commit_eret;
    assign w_do_mtc0     = w_idle_commit & ~w_int_pend & ~commit_syscall & ~commit_eret
                         & commit_mtc0;
    assign w_take_any    = w_take_int | w_take_sys | w_take_eret;

    assign flush          = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign commit_ready   = r_commit_ready;

    // Two-flop synchronizer; its output is the live hardware IP level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_meta <= '0;
            r_irq_sync <= '0;
        end else begin
            r_irq_meta <= irq;
            r_irq_sync <= r_irq_meta;
        end
    end

    // Status/Cause/EPC updates from exceptions, eret and mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_im       <= 8'h00;
            r_exc_code <= 5'd0;
            r_ip_sw    <= 2'b00;
            r_epc      <= 32'h0;
        end else if (w_take_int || w_take_sys) begin
            r_epc      <= commit_pc;
            r_exc_code <= w_take_int ? C_EXC_INT : C_EXC_SYS;
            r_exl      <= 1'b1;
        end else if (w_take_eret) begin
            r_exl <= 1'b0;
        end else if (w_do_mtc0) begin
            case (cp0_waddr)
                C_ADDR_STATUS: begin
                    r_ie  <= cp0_wdata[0];
                    r_exl <= cp0_wdata[1];
                    r_im  <= cp0_wdata[15:8];
                end
                C_ADDR_CAUSE: r_ip_sw <= cp0_wdata[9:8];
                C_ADDR_EPC:   r_epc   <= cp0_wdata;
                default:      ;
            endcase
        end
    end

    // Sequencer: IDLE -> FLUSH (FLUSH_CYCLES) -> REDIRECT (1) -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= C_ST_IDLE;
            r_cnt            <= 3'd0;
            r_target         <= 32'h0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'h0;
            r_commit_ready   <= 1'b1;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_take_any) begin
                        r_state        <= C_ST_FLUSH;
                        r_cnt          <= C_FLUSH_LAST;
                        r_flush        <= 1'b1;
                        r_commit_ready <= 1'b0;
                        // eret returns to the EPC held at acceptance.
                        r_target       <= w_take_eret ? r_epc : EXC_VECTOR;
                    end
                end
                C_ST_FLUSH: begin
                    if (r_cnt == 3'd0) begin
                        r_state          <= C_ST_REDIRECT;
                        r_flush          <= 1'b0;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_target;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                C_ST_REDIRECT: begin
                    r_state          <= C_ST_IDLE;
                    r_redirect_valid <= 1'b0;
                    r_commit_ready   <= 1'b1;
                end
                default: begin
                    r_state          <= C_ST_IDLE;
                    r_flush          <= 1'b0;
                    r_redirect_valid <= 1'b0;
                    r_commit_ready   <= 1'b1;
                end
            endcase
        end
    end

`ifdef TIMER_EN
    // Free-running Count and sticky compare-match pending bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= 32'h0;
            r_compare    <= 32'h0;
            r_timer_pend <= 1'b0;
        end else begin
            if (w_do_mtc0 && (cp0_waddr == C_ADDR_COUNT)) begin
                r_count <= cp0_wdata;
            end else begin
                r_count <= r_count + 32'd1;
            end
            if (w_do_mtc0 && (cp0_waddr == C_ADDR_COMPARE)) begin
                r_compare    <= cp0_wdata;
                r_timer_pend <= 1'b0;
            end else if (r_count == r_compare) begin
                r_timer_pend <= 1'b1;
            end
        end
    end
`endif

    // mfc0 read mux; reflects state after the last edge.
    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_raddr)
            C_ADDR_STATUS: cp0_rdata = {16'h0, r_im, 6'h0, r_exl, r_ie};
            C_ADDR_CAUSE:  cp0_rdata = {16'h0, w_ip, 1'b0, r_exc_code, 2'b00};
            C_ADDR_EPC:    cp0_rdata = r_epc;
`ifdef TIMER_EN
            C_ADDR_COUNT:   cp0_rdata = r_count;
            C_ADDR_COMPARE: cp0_rdata = r_compare;
`endif
            default:       cp0_rdata = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cp0_exc_ctrl                                            |
// | Description : Self-checking bench for cp0_exc_ctrl: a phase-counting     |
// |               reference model checked every cycle, plus directed         |
// |               literal expectations. TIMER_EN enables the timer section.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cp0_exc_ctrl;

    localparam int          F   = 2;
    localparam int          IW  = 5;
    localparam logic [31:0] VEC = 32'h0000_0800;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          commit_valid = 1'b0;
    logic          commit_ready;
    logic [31:0]   commit_pc = 32'h0;
    logic          commit_syscall = 1'b0;
    logic          commit_eret = 1'b0;
    logic          commit_mtc0 = 1'b0;
    logic [4:0]    cp0_waddr = 5'd0;
    logic [31:0]   cp0_wdata = 32'h0;
    logic [4:0]    cp0_raddr = 5'd0;
    logic [31:0]   cp0_rdata;
    logic [IW-1:0] irq = '0;
    logic          flush;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;

    always #5 clk = ~clk;

    cp0_exc_ctrl #(
        .EXC_VECTOR  (VEC),
        .IRQ_WIDTH   (IW),
        .FLUSH_CYCLES(F)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .commit_pc     (commit_pc),
        .commit_syscall(commit_syscall),
        .commit_eret   (commit_eret),
        .commit_mtc0   (commit_mtc0),
        .cp0_waddr     (cp0_waddr),
        .cp0_wdata     (cp0_wdata),
        .cp0_raddr     (cp0_raddr),
        .cp0_rdata     (cp0_rdata),
        .irq           (irq),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase = edges since an event was accepted (0 = idle).
    logic          m_ie, m_exl;
    logic [7:0]    m_im;
    logic [4:0]    m_exc;
    logic [1:0]    m_ipsw;
    logic [IW-1:0] m_s1, m_s2;
    logic [31:0]   m_epc, m_target, m_rpc;
    int            m_phase;

    function automatic logic [7:0] m_ip();
        logic [5:0] hw;
        hw = 6'(m_s2);
        return {hw, m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13:   return {16'h0, m_ip(), 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Model update on every active edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ie <= 1'b0; m_exl <= 1'b0; m_im <= 8'h0; m_exc <= 5'd0; m_ipsw <= 2'b0;
            m_s1 <= '0; m_s2 <= '0; m_epc <= 32'h0; m_target <= 32'h0; m_rpc <= 32'h0;
            m_phase <= 0;
        end else begin
            m_s1 <= irq;
            m_s2 <= m_s1;
            if (m_phase == 0) begin
                if (commit_valid) begin
                    if (m_ie && !m_exl && ((m_ip() & m_im) != 8'h0)) begin
                        m_epc <= commit_pc; m_exc <= 5'd0; m_exl <= 1'b1;
                        m_target <= VEC; m_phase <= 1;
                    end else if (commit_syscall) begin
                        m_epc <= commit_pc; m_exc <= 5'd8; m_exl <= 1'b1;
                        m_target <= VEC; m_phase <= 1;
                    end else if (commit_eret) begin
                        m_exl <= 1'b0; m_target <= m_epc; m_phase <= 1;
                    end else if (commit_mtc0) begin
                        case (cp0_waddr)
                            5'd12: begin
                                m_ie <= cp0_wdata[0]; m_exl <= cp0_wdata[1];
                                m_im <= cp0_wdata[15:8];
                            end
                            5'd13:   m_ipsw <= cp0_wdata[9:8];
                            5'd14:   m_epc  <= cp0_wdata;
                            default: ;
                        endcase
                    end
                end
            end else if (m_phase == F + 1) begin
                m_phase <= 0;
            end else begin
                if (m_phase == F) m_rpc <= m_target;
                m_phase <= m_phase + 1;
            end
        end
    end

    // Per-cycle comparison on the inactive edge.
    always @(negedge clk) begin
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF;
`ifdef TIMER_EN
        if (cp0_raddr == 5'd9 || cp0_raddr == 5'd11) mask = 32'h0;
        else if (cp0_raddr == 5'd13) mask = 32'hFFFF_7FFF;
`endif
        check("cyc_flush", 32'(flush), 32'(m_phase >= 1 && m_phase <= F));
        check("cyc_redirect_valid", 32'(redirect_valid), 32'(m_phase == F + 1));
        check("cyc_commit_ready", 32'(commit_ready), 32'(m_phase == 0));
        check("cyc_redirect_pc", redirect_pc, m_rpc);
        if (mask != 32'h0) check("cyc_rdata", cp0_rdata & mask, m_read(cp0_raddr) & mask);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic commit(input logic [31:0] pc, input logic sys, input logic er,
                          input logic mt, input logic [4:0] wa, input logic [31:0] wd);
        commit_valid = 1'b1; commit_pc = pc; commit_syscall = sys; commit_eret = er;
        commit_mtc0 = mt; cp0_waddr = wa; cp0_wdata = wd;
        step();
        commit_valid = 1'b0; commit_syscall = 1'b0; commit_eret = 1'b0; commit_mtc0 = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
        commit(32'h0000_0100, 1'b0, 1'b0, 1'b1, wa, wd);
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        cp0_raddr = a;
        #1;
        check(name, cp0_rdata, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        step();
        check("rst_commit_ready", 32'(commit_ready), 32'h1);
        rd_check("rst_status", 5'd12, 32'h0);
        rd_check("rst_cause", 5'd13, 32'h0);
        rd_check("rst_epc", 5'd14, 32'h0);
        rst_n = 1'b1;
        step();

        // Syscall
        mtc0(5'd12, 32'h0000_0001);
        rd_check("st_ie", 5'd12, 32'h1);
        commit(32'h0000_1000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("sys_flush0", 32'(flush), 32'h1);
        rd_check("sys_epc", 5'd14, 32'h0000_1000);
        rd_check("sys_cause", 5'd13, 32'h0000_0020);
        rd_check("sys_status", 5'd12, 32'h0000_0003);
        // Commit inputs held during the sequence must be ignored.
        commit_valid = 1'b1; commit_mtc0 = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD;
        step();
        check("sys_flush1", 32'(flush), 32'h1);
        check("sys_ready1", 32'(commit_ready), 32'h0);
        step();
        commit_valid = 1'b0; commit_mtc0 = 1'b0;
        check("sys_redir_v", 32'(redirect_valid), 32'h1);
        check("sys_redir_pc", redirect_pc, 32'h0000_0800);
        check("sys_redir_flush", 32'(flush), 32'h0);
        step();
        check("sys_ready", 32'(commit_ready), 32'h1);
        check("sys_rpc_hold", redirect_pc, 32'h0000_0800);
        rd_check("sys_epc_kept", 5'd14, 32'h0000_1000);

        // Eret
        mtc0(5'd14, 32'h0000_1004);
        commit(32'h0000_0200, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        check("eret_flush", 32'(flush), 32'h1);
        rd_check("eret_status", 5'd12, 32'h0000_0001);
        idle(2);
        check("eret_redir_v", 32'(redirect_valid), 32'h1);
        check("eret_redir_pc", redirect_pc, 32'h0000_1004);
        step();

        // Interrupt taken
        mtc0(5'd12, 32'h0000_0401);
        irq = 5'b00001;
        idle(3);
        rd_check("int_cause_ip", 5'd13, 32'h0000_0420);
        commit(32'h0000_2000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("int_flush", 32'(flush), 32'h1);
        rd_check("int_epc", 5'd14, 32'h0000_2000);
        rd_check("int_cause", 5'd13, 32'h0000_0400);
        rd_check("int_status", 5'd12, 32'h0000_0403);
        idle(2);
        check("int_redir_pc", redirect_pc, 32'h0000_0800);
        step();

        // Masked by EXL
        commit(32'h0000_2100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("exl_no_flush", 32'(flush), 32'h0);
        rd_check("exl_epc", 5'd14, 32'h0000_2000);
        // Masked by IM
        mtc0(5'd12, 32'h0000_0001);
        commit(32'h0000_2200, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("im_no_flush", 32'(flush), 32'h0);
        rd_check("im_epc", 5'd14, 32'h0000_2000);

        // Priority: interrupt beats syscall and mtc0 together
        mtc0(5'd12, 32'h0000_0401);
        commit(32'h0000_3000, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_FF01);
        check("pri_flush", 32'(flush), 32'h1);
        rd_check("pri_cause", 5'd13, 32'h0000_0400);
        rd_check("pri_epc", 5'd14, 32'h0000_3000);
        rd_check("pri_status", 5'd12, 32'h0000_0403);
        idle(2);
        check("pri_redir_pc", redirect_pc, 32'h0000_0800);
        step();
        irq = '0;
        idle(3);

        // mtc0 masking / mfc0
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd_check("mt_status", 5'd12, 32'h0000_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd_check("mt_cause", 5'd13, 32'h0000_0300);
        mtc0(5'd20, 32'hFFFF_FFFF);
        rd_check("mt_reg20", 5'd20, 32'h0);
        mtc0(5'd12, 32'h0);
        mtc0(5'd13, 32'h0);

        // Reset in the first flush cycle
        mtc0(5'd12, 32'h0000_0001);
        commit(32'h0000_4000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("rmid_flush_before", 32'(flush), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rmid_flush", 32'(flush), 32'h0);
        check("rmid_ready", 32'(commit_ready), 32'h1);
        idle(2);
        rd_check("rmid_status", 5'd12, 32'h0);
        rd_check("rmid_cause", 5'd13, 32'h0);
        rd_check("rmid_epc", 5'd14, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rmid_no_redirect", 32'(redirect_valid), 32'h0);
        end

`ifdef TIMER_EN
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'h5);
        cp0_raddr = 5'd13;
        #1;
        check("tmr_cleared", cp0_rdata & 32'h8000, 32'h0);
        idle(4);
        check("tmr_before_match", cp0_rdata & 32'h8000, 32'h0);
        step();
        check("tmr_match", cp0_rdata & 32'h8000, 32'h8000);
        mtc0(5'd11, 32'h100);
        check("tmr_compare_clear", cp0_rdata & 32'h8000, 32'h0);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
